// File: rtl/plru_tracker_pkg.sv
// -----------------------------------------------------------------------------
// plru_tracker_pkg
//   Shared types and constants for the 4-way tree pseudo-LRU tracker.
//   lc3b_plru  : 3-bit victim-pointer tree state
//                [0]=1 victim in {a,b}, 0 victim in {c,d}
//                [1]=1 victim a else b, [2]=1 victim c else d
//   lc3b_way   : 2-bit way number, 0=a 1=b 2=c 3=d
//   PLRU_RESET : state every set takes on reset or flush
//   Optional feature macro: LRU_FLUSH_EN (flush sweep FSM; uses sweep_state_e)
// -----------------------------------------------------------------------------
package plru_tracker_pkg;

   typedef logic [2:0] lc3b_plru;
   typedef logic [1:0] lc3b_way;

   localparam lc3b_plru PLRU_RESET = 3'b000;

   localparam lc3b_way WAY_A = 2'd0;
   localparam lc3b_way WAY_B = 2'd1;
   localparam lc3b_way WAY_C = 2'd2;
   localparam lc3b_way WAY_D = 2'd3;

   typedef enum logic {
      SWEEP_IDLE = 1'b0,
      SWEEP_RUN  = 1'b1
   } sweep_state_e;

endpackage

// File: rtl/plru_tracker_if.sv
// -----------------------------------------------------------------------------
// plru_tracker_if
//   Bundles the lookup, access and (optionally) flush signals of plru_tracker.
//   master : cache controller side (drives lookup/access/flush, sees lru/busy)
//   slave  : plru_tracker side
//   Signals:
//     lookup_valid/lookup_set        request the PLRU state of a set
//     lru/lru_valid                  state of the set looked up last cycle
//     access_valid/access_set/way    hit or fill touching one way of a set
//     flush_req/busy                 only with LRU_FLUSH_EN defined
// -----------------------------------------------------------------------------
interface plru_tracker_if
   import plru_tracker_pkg::*;
#(
   parameter int NUM_SETS = 8
);
   localparam int INDEX_W = $clog2(NUM_SETS);

   logic               lookup_valid;
   logic [INDEX_W-1:0] lookup_set;
   lc3b_plru           lru;
   logic               lru_valid;
   logic               access_valid;
   logic [INDEX_W-1:0] access_set;
   lc3b_way            access_way;
`ifdef LRU_FLUSH_EN
   logic               flush_req;
   logic               busy;
`endif

   modport master (
      output lookup_valid, lookup_set, access_valid, access_set, access_way,
`ifdef LRU_FLUSH_EN
      output flush_req,
      input  busy,
`endif
      input  lru, lru_valid
   );

   modport slave (
      input  lookup_valid, lookup_set, access_valid, access_set, access_way,
`ifdef LRU_FLUSH_EN
      input  flush_req,
      output busy,
`endif
      output lru, lru_valid
   );

endinterface

// File: rtl/plru_tracker_next.sv
// -----------------------------------------------------------------------------
// plru_next
//   Combinational PLRU next-state: points the tree away from the touched way;
//   the bit belonging to the untouched pair keeps its value.
//   cur_i : current set state
//   way_i : way being touched
//   nxt_o : state after the touch
// -----------------------------------------------------------------------------
module plru_next
   import plru_tracker_pkg::*;
(
   input  lc3b_plru cur_i,
   input  lc3b_way  way_i,
   output lc3b_plru nxt_o
);

   always_comb begin
      // NOTE: every output gets a default before the case so no path can leave
      // it unassigned and infer a latch.
      nxt_o = cur_i;
      unique case (way_i)
         WAY_A: begin nxt_o[0] = 1'b0; nxt_o[1] = 1'b0; end
         WAY_B: begin nxt_o[0] = 1'b0; nxt_o[1] = 1'b1; end
         WAY_C: begin nxt_o[0] = 1'b1; nxt_o[2] = 1'b0; end
         WAY_D: begin nxt_o[0] = 1'b1; nxt_o[2] = 1'b1; end
      endcase
   end

endmodule

// File: rtl/plru_tracker.sv
// -----------------------------------------------------------------------------
// plru_tracker
//   Per-set 3-bit tree pseudo-LRU state for a 4-way cache. A lookup returns the
//   set's state one cycle later on lru/lru_valid; a hit or fill updates the set.
//   A lookup colliding with an access to the same set sees the updated state.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    plru_tracker_if.slave (lookup, access, lru result, flush/busy)
//   Optional feature macro: LRU_FLUSH_EN adds flush_req/busy and a sweep FSM
//   that clears one set per cycle for NUM_SETS cycles.
// -----------------------------------------------------------------------------
module plru_tracker
   import plru_tracker_pkg::*;
#(
   parameter  int NUM_SETS = 8,
   localparam int INDEX_W  = $clog2(NUM_SETS)
) (
   input logic           clk,
   input logic           rst_n,
   plru_tracker_if.slave bus
);

   lc3b_plru state_q [NUM_SETS];
   lc3b_plru state_d [NUM_SETS];
   lc3b_plru acc_next;
   lc3b_plru lru_q, lru_d;
   logic     lru_valid_q, lru_valid_d;
   logic     sweep_active;
   logic     acc_en, lk_en;

   plru_next u_next (
      .cur_i (state_q[bus.access_set]),
      .way_i (bus.access_way),
      .nxt_o (acc_next)
   );

`ifdef LRU_FLUSH_EN
   sweep_state_e       fsm_q;
   logic [INDEX_W-1:0] cnt_q;
   logic               busy_q;

   // Sweep FSM: busy is registered so it rises the cycle after flush_req and
   // stays high for exactly NUM_SETS cycles, one set cleared per cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q  <= SWEEP_IDLE;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         unique case (fsm_q)
            SWEEP_IDLE: begin
               if (bus.flush_req) begin
                  fsm_q  <= SWEEP_RUN;
                  cnt_q  <= '0;
                  busy_q <= 1'b1;
               end
            end
            SWEEP_RUN: begin
               if (cnt_q == INDEX_W'(NUM_SETS - 1)) begin
                  fsm_q  <= SWEEP_IDLE;
                  cnt_q  <= '0;
                  busy_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + INDEX_W'(1);
               end
            end
         endcase
      end
   end

   assign sweep_active = busy_q;
   assign bus.busy     = busy_q;
`else
   assign sweep_active = 1'b0;
`endif

   // Accesses and lookups are both locked out while the sweep owns the array.
   assign acc_en = bus.access_valid & ~sweep_active;
   assign lk_en  = bus.lookup_valid & ~sweep_active;

   always_comb begin
      state_d = state_q;
      if (acc_en) begin
         state_d[bus.access_set] = acc_next;
      end
`ifdef LRU_FLUSH_EN
      if (busy_q) begin
         state_d[cnt_q] = PLRU_RESET;
      end
`endif
      lru_valid_d = lk_en;
      lru_d       = lru_q;
      if (lk_en) begin
         // Write-through bypass: a same-cycle access to the looked-up set is
         // visible in the result.
         lru_d = (acc_en && (bus.lookup_set == bus.access_set)) ? acc_next
                                                               : state_q[bus.lookup_set];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the state array is flop-based and must read PLRU_RESET right
         // after reset, so it is cleared here like any other register.
         state_q     <= '{default: PLRU_RESET};
         lru_q       <= PLRU_RESET;
         lru_valid_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only, so all
         // registers update together from pre-edge values.
         state_q     <= state_d;
         lru_q       <= lru_d;
         lru_valid_q <= lru_valid_d;
      end
   end

   assign bus.lru       = lru_q;
   assign bus.lru_valid = lru_valid_q;

endmodule

// File: tb/tb_plru_tracker.sv
// -----------------------------------------------------------------------------
// tb_plru_tracker
//   Scoreboard bench for plru_tracker (NUM_SETS=8). The driver applies one
//   stimulus per cycle, updates a reference model of the replacement tree and
//   queues the expected lookup result; a monitor pops and compares whenever
//   lru_valid is seen. Builds with or without LRU_FLUSH_EN.
// -----------------------------------------------------------------------------
module tb_plru_tracker;
   import plru_tracker_pkg::*;

   localparam int NUM_SETS = 8;
   localparam int IW       = $clog2(NUM_SETS);
`ifdef LRU_FLUSH_EN
   localparam bit FLUSH_BUILD = 1'b1;
`else
   localparam bit FLUSH_BUILD = 1'b0;
`endif

   logic clk;
   logic rst_n;

   plru_tracker_if #(.NUM_SETS(NUM_SETS)) bus ();

   plru_tracker #(.NUM_SETS(NUM_SETS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: which pair holds the victim, and which member of each
   // pair is the victim (0 = first, 1 = second).
   int victim_pair    [NUM_SETS];
   int victim_in_pair [NUM_SETS][2];
   int sweep_left = 0;
   int sweep_idx  = 0;
   int busy_seen  = 0;

   function automatic void model_clear(input int s);
      victim_pair[s]       = 1;   // reset state points at pair {c,d}
      victim_in_pair[s][0] = 1;   // ... b within {a,b}
      victim_in_pair[s][1] = 1;   // ... d within {c,d}
   endfunction

   function automatic void model_reset();
      for (int s = 0; s < NUM_SETS; s++) model_clear(s);
      sweep_left = 0;
      sweep_idx  = 0;
   endfunction

   function automatic void model_touch(input int s, input int w);
      victim_pair[s]             = 1 - (w / 2);
      victim_in_pair[s][w / 2]   = 1 - (w % 2);
   endfunction

   function automatic logic [2:0] model_encode(input int s);
      logic [2:0] r;
      r[0] = (victim_pair[s] == 0);
      r[1] = (victim_in_pair[s][0] == 0);
      r[2] = (victim_in_pair[s][1] == 0);
      return r;
   endfunction

   typedef struct {
      int         edge_no;
      logic [2:0] lru;
      int         set;
   } exp_t;

   exp_t     sb_q[$];
   int       edge_cnt = 0;
   lc3b_plru held     = PLRU_RESET;

   // Monitor: compares lookup results; between results lru must hold.
   always @(posedge clk) begin
      exp_t e;
      edge_cnt++;
      #1;
      if (rst_n) begin
         if (bus.lru_valid) begin
            if (sb_q.size() == 0) begin
               check("spurious_lru_valid", 32'(bus.lru_valid), 32'(0));
            end else begin
               e = sb_q.pop_front();
               check($sformatf("lru_valid_edge_set%0d", e.set), 32'(edge_cnt), 32'(e.edge_no));
               check($sformatf("lru_set%0d", e.set), 32'(bus.lru), 32'(e.lru));
               held = e.lru;
            end
         end else begin
            check("lru_hold", 32'(bus.lru), 32'(held));
         end
      end
   end

   task automatic set_inputs(input bit lv, input int ls, input bit av, input int as,
                             input int aw, input bit fr);
      logic [31:0] lsv, asv, awv;
      lsv = 32'(ls);
      asv = 32'(as);
      awv = 32'(aw);
      bus.lookup_valid = lv;
      bus.lookup_set   = lsv[IW-1:0];
      bus.access_valid = av;
      bus.access_set   = asv[IW-1:0];
      bus.access_way   = awv[1:0];
`ifdef LRU_FLUSH_EN
      bus.flush_req    = fr;
`else
      if (fr) begin end
`endif
   endtask

   // One cycle of stimulus: drive at the falling edge, then advance the model
   // to what the next rising edge must produce.
   task automatic drive(input bit lv, input int ls, input bit av, input int as,
                        input int aw, input bit fr);
      @(negedge clk);
`ifdef LRU_FLUSH_EN
      check("busy", 32'(bus.busy), 32'(sweep_left > 0));
      if (bus.busy) busy_seen++;
`endif
      set_inputs(lv, ls, av, as, aw, fr);
      if (sweep_left > 0) begin
         model_clear(sweep_idx);
         sweep_idx++;
         sweep_left--;
      end else begin
         if (av) model_touch(as, aw);
         if (lv) sb_q.push_back('{edge_cnt + 1, model_encode(ls), ls});
         if (fr && FLUSH_BUILD) begin
            sweep_left = NUM_SETS;
            sweep_idx  = 0;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) drive(0, 0, 0, 0, 0, 0);
   endtask

   task automatic random_cycle(input bit allow_flush);
      int  ls, as;
      bit  fr;
      ls = $urandom_range(0, NUM_SETS - 1);
      as = ($urandom_range(0, 1) == 1) ? ls : $urandom_range(0, NUM_SETS - 1);
      fr = allow_flush && ($urandom_range(0, 39) == 0);
      drive($urandom_range(0, 1), ls, $urandom_range(0, 1), as, $urandom_range(0, 3), fr);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_lru"},       32'(bus.lru),       32'(PLRU_RESET));
      check({tag, "_lru_valid"}, 32'(bus.lru_valid), 32'(0));
`ifdef LRU_FLUSH_EN
      check({tag, "_busy"},      32'(bus.busy),      32'(0));
`endif
   endtask

   // Reset mid-cycle with a lookup pending; outputs must clear without a clock.
   task automatic async_reset();
      drive(1, $urandom_range(0, NUM_SETS - 1), 1, $urandom_range(0, NUM_SETS - 1),
            $urandom_range(0, 3), 0);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("async_reset");
      sb_q.delete();
      model_reset();
      held = PLRU_RESET;
      @(negedge clk);
      set_inputs(0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      set_inputs(0, 0, 0, 0, 0, 0);
      model_reset();
      #1 check_reset_outputs("power_on_reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Every set reads the reset state.
      for (int s = 0; s < NUM_SETS; s++) drive(1, s, 0, 0, 0, 0);

      // Set 3 walked through a, b, c, d with a lookup after each access.
      for (int w = 0; w < 4; w++) begin
         drive(0, 0, 1, 3, w, 0);
         drive(1, 3, 0, 0, 0, 0);
      end

      // Same-cycle access and lookup of set 5 (bypass).
      drive(1, 5, 1, 5, 2, 0);
      // Access set 2 while looking up set 4, then look up set 2.
      drive(1, 4, 1, 2, 3, 0);
      drive(1, 2, 0, 0, 0, 0);
      // Back-to-back accesses to one set, looked up on the last one.
      drive(0, 0, 1, 6, 1, 0);
      drive(0, 0, 1, 6, 3, 0);
      drive(1, 6, 1, 6, 0, 0);
      drive(1, 6, 0, 0, 0, 0);

      repeat (400) random_cycle(1'b1);
      idle(NUM_SETS + 2);

      // Populate every set with a non-reset state, then reset mid-stream.
      for (int s = 0; s < NUM_SETS; s++) drive(0, 0, 1, s, $urandom_range(1, 3), 0);
      drive(1, 0, 0, 0, 0, 0);
      async_reset();
      for (int s = 0; s < NUM_SETS; s++) drive(1, s, 0, 0, 0, 0);

`ifdef LRU_FLUSH_EN
      repeat (24) random_cycle(1'b0);
      busy_seen = 0;
      // Flush together with an access: the access lands, then the sweep wipes it.
      drive(1, 1, 1, 1, 3, 1);
      // Activity during the sweep, including flush requests, must be ignored.
      repeat (NUM_SETS) drive($urandom_range(0, 1), $urandom_range(0, NUM_SETS - 1), 1,
                              $urandom_range(0, NUM_SETS - 1), $urandom_range(0, 3),
                              $urandom_range(0, 1));
      drive(0, 0, 0, 0, 0, 0);
      check("busy_cycles", 32'(busy_seen), 32'(NUM_SETS));
      for (int s = 0; s < NUM_SETS; s++) drive(1, s, 0, 0, 0, 0);
      repeat (100) random_cycle(1'b1);
      idle(NUM_SETS + 2);
`endif

      idle(4);
      check("scoreboard_drained", 32'(sb_q.size()), 32'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
